// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared rv32i types: branch funct3 encodings and the iterative comparator state.
package rv32i_types;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } branch_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_iter_state_t;

  // Map a scan outcome onto the branch decision; undefined funct3 never branches.
  function automatic logic branch_result(
    input logic [2:0] op,
    input logic       decided,
    input logic       ltu_r,
    input logic       a_msb,
    input logic       b_msb
  );
    logic eq;
    logic ltu;
    logic lt;
    eq  = !decided;
    ltu = decided && ltu_r;
    lt  = (a_msb ^ b_msb) ? a_msb : ltu;
    case (op)
      BEQ:     branch_result = eq;
      BNE:     branch_result = !eq;
      BLT:     branch_result = lt;
      BGE:     branch_result = !lt;
      BLTU:    branch_result = ltu;
      BGEU:    branch_result = !ltu;
      default: branch_result = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cmp_iter_chunk.sv
// rtl/cmp_iter_chunk.sv - single-chunk unsigned comparator used by the iterative branch comparator.
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_c,
  input  logic [CHUNK-1:0] b_c,
  output logic             neq,
  output logic             ltu
);

  assign neq = (a_c != b_c);
  assign ltu = (a_c < b_c);

endmodule

// File: rtl/cmp_iter.sv
// rtl/cmp_iter.sv - multi-cycle rv32i branch comparator scanning operands MSB-first, CHUNK bits per cycle.
module cmp_iter
  import rv32i_types::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       cmpop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             f,
  output logic             busy
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("cmp_iter: WIDTH must be a multiple of CHUNK");
  end

  cmp_iter_state_t  state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             decided_q, decided_d;
  logic             ltu_r_q, ltu_r_d;
  logic             f_q, f_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic             c_neq;
  logic             c_ltu;

  // One comparator shared across all chunk positions, steered by idx.
  assign a_chunk = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign b_chunk = b_q[int'(idx_q)*CHUNK +: CHUNK];

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_c (a_chunk),
    .b_c (b_chunk),
    .neq (c_neq),
    .ltu (c_ltu)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    ltu_r_d   = ltu_r_q;
    f_d       = f_q;

    if (flush) begin
      state_d   = IDLE;
      f_d       = 1'b0;
      decided_d = 1'b0;
      ltu_r_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            a_d       = a;
            b_d       = b;
            op_d      = cmpop;
            idx_d     = LAST_IDX;
            decided_d = 1'b0;
            ltu_r_d   = 1'b0;
            state_d   = SCAN;
          end
        end
        SCAN: begin
          // A differing chunk or the last chunk both end the scan; c_neq doubles as decided.
          if (c_neq || (idx_q == '0)) begin
            decided_d = c_neq;
            ltu_r_d   = c_neq && c_ltu;
            f_d       = branch_result(op_q, c_neq, c_ltu, a_q[WIDTH-1], b_q[WIDTH-1]);
            state_d   = DONE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state_d = IDLE;
            f_d     = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          f_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      ltu_r_q   <= 1'b0;
      f_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      ltu_r_q   <= ltu_r_d;
      f_q       <= f_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign f          = f_q;

endmodule

// File: tb/tb_cmp_iter.sv
// tb/tb_cmp_iter.sv - self-checking scoreboard bench for cmp_iter (32/8 and 16/4 instances).
module tb_cmp_iter;
  import rv32i_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic        req_valid, resp_ready;
  logic [2:0]  cmpop;
  logic [31:0] a, b;
  logic        req_ready, resp_valid, f, busy;

  logic        req_valid16, resp_ready16;
  logic [2:0]  cmpop16;
  logic [15:0] a16, b16;
  logic        req_ready16, resp_valid16, f16, busy16;

  cmp_iter #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .cmpop(cmpop), .a(a), .b(b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .f(f), .busy(busy)
  );

  cmp_iter #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid16), .req_ready(req_ready16),
    .cmpop(cmpop16), .a(a16), .b(b16),
    .resp_valid(resp_valid16), .resp_ready(resp_ready16),
    .f(f16), .busy(busy16)
  );

  int passed = 0;
  int total  = 0;

  logic exp_f_q[$];
  int   exp_k_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic gold(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      3'b000:  return x == y;
      3'b001:  return x != y;
      3'b100:  return $signed(x) <  $signed(y);
      3'b101:  return $signed(x) >= $signed(y);
      3'b110:  return x <  y;
      3'b111:  return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  // Edges from accept to resp_valid: 4 minus the chunk holding the highest differing bit.
  function automatic int gold_k(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] d;
    d = x ^ y;
    for (int i = 31; i >= 0; i--)
      if (d[i]) return 4 - i / 8;
    return 4;
  endfunction

  task automatic run_txn(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input int stall);
    int   edges;
    logic fh;
    logic ef;
    int   ek;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1'b1);
    req_valid  = 1'b1;
    cmpop      = op;
    a          = av;
    b          = bv;
    resp_ready = (stall == 0);
    exp_f_q.push_back(gold(op, av, bv));
    exp_k_q.push_back(gold_k(av, bv));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    a         = $urandom;
    b         = $urandom;
    cmpop     = 3'($urandom);
    edges     = 0;
    while (1) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (resp_valid || edges > 40) break;
    end
    ef = exp_f_q.pop_front();
    ek = exp_k_q.pop_front();
    check("latency", edges, ek);
    check("f", f, ef);
    if (stall > 0) begin
      fh = f;
      repeat (stall) begin
        @(negedge clk);
        check("bp_resp_valid", resp_valid, 1'b1);
        check("bp_f_stable", f, fh);
        check("bp_req_ready", req_ready, 1'b0);
        check("bp_busy", busy, 1'b1);
      end
      resp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("post_resp_valid", resp_valid, 1'b0);
    check("post_req_ready", req_ready, 1'b1);
  endtask

  initial begin
    int   edges;
    logic saw;
    logic [31:0] ra, rb;
    rst = 1'b0; flush = 1'b0;
    req_valid = 1'b0; resp_ready = 1'b0; cmpop = '0; a = '0; b = '0;
    req_valid16 = 1'b0; resp_ready16 = 1'b0; cmpop16 = '0; a16 = '0; b16 = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_f", f, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    run_txn(BEQ,  32'h0000_0005, 32'h0000_0005, 0);
    run_txn(BNE,  32'h0000_0005, 32'h0000_0005, 0);
    run_txn(BLTU, 32'h0100_0000, 32'h0000_0000, 0);
    run_txn(BGEU, 32'h0100_0000, 32'h0000_0000, 0);
    run_txn(BLT,  32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_txn(BLTU, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_txn(BGE,  32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_txn(BGEU, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_txn(BNE,  32'h0000_0010, 32'h0000_0011, 5);
    run_txn(3'b010, 32'h0000_0005, 32'h0000_0005, 0);
    run_txn(3'b011, 32'h1234_0000, 32'h1200_0000, 0);

    // Flush during the second SCAN cycle.
    @(negedge clk);
    req_valid = 1'b1; cmpop = BEQ; a = 32'h5; b = 32'h5; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_req_ready", req_ready, 1'b1);
    check("flush_resp_valid", resp_valid, 1'b0);
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) saw = 1'b1;
    end
    check("flush_no_resp", saw, 1'b0);

    // A request presented together with flush is dropped.
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("flush_blocks_req", busy, 1'b0);
    flush = 1'b0; req_valid = 1'b0;

    // Asynchronous reset mid-scan.
    @(negedge clk);
    req_valid = 1'b1; cmpop = BEQ; a = 32'h5; b = 32'h5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_resp_valid", resp_valid, 1'b0);
    check("arst_req_ready", req_ready, 1'b1);
    check("arst_f", f, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) saw = 1'b1;
    end
    check("arst_no_resp", saw, 1'b0);
    resp_ready = 1'b0;

    // 16-bit / 4-bit-chunk instance: sign decides in the first chunk.
    @(negedge clk);
    req_valid16 = 1'b1; cmpop16 = BLT; a16 = 16'h8000; b16 = 16'h7FFF; resp_ready16 = 1'b1;
    exp_f_q.push_back(1'b1);
    exp_k_q.push_back(1);
    @(posedge clk);
    @(negedge clk);
    req_valid16 = 1'b0;
    edges = 0;
    while (1) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (resp_valid16 || edges > 40) break;
    end
    check("w16_latency", edges, exp_k_q.pop_front());
    check("w16_f", f16, exp_f_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    check("w16_idle", req_ready16, 1'b1);

    // Random sweep against the golden model.
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
        2:       rb = {ra[31:16], 16'($urandom)};
        default: rb = $urandom;
      endcase
      run_txn(3'($urandom), ra, rb, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
